fir: RTL and testbench

FIR -- requirements
Module: fir

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_saturate.sv | 38 +++
 rtl/fir.sv | 68 ++++++
 tb/tb_fir.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the FIR: Q1.15 coefficient format, default taps and accumulator sizing.
// SATURATE_EN mirrors the FIR_SATURATE_EN build macro so other code can see which output mode was built.
package fir_pkg;

  localparam int COEF_W        = 16;
  localparam int COEF_FRAC     = 15;
  localparam int NUM_DEF_COEFS = 3;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam coef_t DEF_COEFS [NUM_DEF_COEFS] = '{-16'sd9600, 16'sd16384, 16'sd9626};

`ifdef FIR_SATURATE_EN
  localparam bit SATURATE_EN = 1'b1;
`else
  localparam bit SATURATE_EN = 1'b0;
`endif

  // Wide enough to hold the exact sum of num_taps full-scale products.
  function automatic int acc_width(input int data_w, input int num_taps);
    return data_w + COEF_W + $clog2(num_taps);
  endfunction

  // Taps beyond the default set contribute nothing.
  function automatic coef_t coef_at(input int k);
    if (k < NUM_DEF_COEFS) return DEF_COEFS[k];
    return '0;
  endfunction

endpackage

// File: rtl/fir_saturate.sv
// Converts the Q1.15-scaled accumulator to a DATA_W sample: floor shift by COEF_FRAC, then
// clamp when FIR_SATURATE_EN is defined, otherwise keep the low DATA_W bits (wrap).
module fir_saturate
  import fir_pkg::*;
#(
  parameter int ACC_W  = 26,
  parameter int DATA_W = 8
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0] shifted;
  logic                    unused_bits;

  // Arithmetic shift on a signed value rounds toward minus infinity.
  assign shifted     = acc >>> COEF_FRAC;
  assign unused_bits = ^{acc[COEF_FRAC-1:0], shifted[ACC_W-1:DATA_W]};

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  assign result = shifted[DATA_W-1:0];
`endif

endmodule

// File: rtl/fir.sv
// Direct-form FIR: NUM_TAPS delay line, exact MAC, floor-shifted output with 2-clock latency.
// Output mode (clamp vs wrap) is selected by the FIR_SATURATE_EN macro inside fir_saturate.
module fir
  import fir_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_TAPS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int ACC_W = acc_width(DATA_W, NUM_TAPS);

  logic signed [DATA_W-1:0] x [NUM_TAPS];
  logic                     stage1_valid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
    end else if (in_valid) begin
      x[0] <= in;
      for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc = acc + ACC_W'(x[k]) * ACC_W'(coef_at(k));
    end
  end

  fir_saturate #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_saturate (
    .acc    (acc),
    .result (result)
  );

  // out/out_valid: a result is offered while out_valid=1 and consumed on an edge with
  // out_ready=1. There is no backpressure: a fresh result always overwrites out and
  // keeps out_valid set, even if the previous one was never consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1_valid <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
    end else begin
      stage1_valid <= in_valid;
      if (stage1_valid) begin
        out       <= result;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir.sv
// Directed bench for fir (DATA_W=8, NUM_TAPS=3) built with FIR_SATURATE_EN; overflow
// vectors follow whichever output mode fir_pkg reports was actually compiled.
`ifndef FIR_SATURATE_EN
`define FIR_SATURATE_EN
`endif

module tb_fir;

  logic              clk;
  logic              rst;
  logic signed [7:0] din;
  logic              in_valid;
  logic signed [7:0] out;
  logic              out_valid;
  logic              out_ready;

  int applied;
  int miscompares;

  typedef struct {
    bit do_reset;
    bit in_valid;
    int din;
    bit out_ready;
    bit exp_valid;
    int exp_raw;
  } vec_t;

  vec_t vecs[$];

  fir #(.DATA_W(8), .NUM_TAPS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] fit(input int raw);
    if (fir_pkg::SATURATE_EN) begin
      if (raw > 127) return 8'h7F;
      if (raw < -128) return 8'h80;
    end
    return raw[7:0];
  endfunction

  function automatic void add(bit r, bit v, int d, bit rdy, bit ev, int eo);
    vec_t t;
    t.do_reset  = r;
    t.in_valid  = v;
    t.din       = d;
    t.out_ready = rdy;
    t.exp_valid = ev;
    t.exp_raw   = eo;
    vecs.push_back(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input bit chk_v, input logic exp_v,
                       input logic [7:0] exp_o);
    applied++;
    if ((chk_v && out_valid !== exp_v) || out !== exp_o) begin
      miscompares++;
      $display("FAIL %s: got out_valid=%0b out=%0d, expected out_valid=%0b out=%0d",
               name, out_valid, out, exp_v, $signed(exp_o));
    end
  endtask

  task automatic apply_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    din      = '0;
    #1;
    check("reset_async", 1'b1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst         = 1'b1;
    din         = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;

    // Impulse then constant 127.
    add(1,1,127,1,0,0);  add(0,1,0,1,1,-38);  add(0,1,0,1,1,63);   add(0,1,0,1,1,37);
    add(0,1,0,1,1,0);    add(0,1,127,1,1,0);  add(0,1,127,1,1,-38); add(0,1,127,1,1,26);
    add(0,1,127,1,1,63); add(0,1,127,1,1,63); add(0,1,127,1,1,63);
    // Positive and negative overflow.
    add(1,1,127,1,0,0);  add(0,1,127,1,1,-38); add(0,1,-128,1,1,26);
    add(0,1,0,1,1,138);  add(0,1,0,1,1,-27);
    add(1,1,-128,1,0,0); add(0,1,-128,1,1,37); add(0,1,127,1,1,-27);
    add(0,1,0,1,1,-139); add(0,1,0,1,1,25);
    // in_valid gap with out_ready=1.
    add(1,1,127,1,0,0);  add(0,1,0,1,1,-38);   add(0,0,55,1,1,63);  add(0,0,55,1,0,63);
    add(0,0,55,1,0,63);  add(0,0,55,1,0,63);   add(0,1,0,1,0,63);   add(0,1,0,1,1,37);
    add(0,0,0,1,1,0);    add(0,0,0,1,0,0);
    // Same gap with out_ready=0, then consumer wakes up.
    add(1,1,127,0,0,0);  add(0,1,0,0,1,-38);   add(0,0,55,0,1,63);  add(0,0,55,0,1,63);
    add(0,0,55,0,1,63);  add(0,0,55,0,1,63);   add(0,0,55,1,0,63);  add(0,1,0,1,0,63);
    add(0,0,0,1,1,37);

    step();
    apply_reset();
    check("post_reset", 1'b1, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) apply_reset();
      in_valid  = vecs[i].in_valid;
      din       = 8'(vecs[i].din);
      out_ready = vecs[i].out_ready;
      step();
      check($sformatf("vec%0d", i), 1'b1, vecs[i].exp_valid, fit(vecs[i].exp_raw));
    end

    // Zero input with random valid/ready keeps out at zero.
    apply_reset();
    din = '0;
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
      check("zero_in", 1'b0, 1'b0, 8'h00);
    end

    // Reset held while a non-zero stream is driven.
    rst       = 1'b0;
    din       = 8'hAA;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("held_reset", 1'b1, 1'b0, 8'h00);
    end
    rst       = 1'b1;
    out_ready = 1'b1;

    // Mid-stream reset drops all history.
    din = 8'sd127;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("midstream_async", 1'b1, 1'b0, 8'h00);
    repeat (2) step();
    rst = 1'b1;
    din = '0;
    step();
    check("after_release0", 1'b1, 1'b0, 8'h00);
    step();
    check("after_release1", 1'b1, 1'b1, 8'h00);
    step();
    check("after_release2", 1'b1, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
